// File: rtl/instruction_aligner_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instruction_aligner_if                                        |
// | Brief    : Fetch-side bus bundle: program memory port, redirect, decode. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface instruction_aligner_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_is_c;

    modport master (
        output mem_addr,
        input  mem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc,
        output instr_is_c
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc,
        input  instr_is_c
    );
endinterface
`default_nettype wire

// File: rtl/instruction_aligner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instruction_aligner                                           |
// | Brief    : Rebuilds 16/32-bit instructions from 32-bit fetch words.      |
// |            INSTR_ALIGNER_RVC_EN enables compressed (16-bit) support.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module instruction_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    instruction_aligner_if.master bus
);

`ifdef INSTR_ALIGNER_RVC_EN
    localparam logic [31:0] c_PC_MASK = 32'hFFFF_FFFE;
`else
    localparam logic [31:0] c_PC_MASK = 32'hFFFF_FFFC;
`endif
    localparam logic [31:0] c_RESET_PC = RESET_PC & c_PC_MASK;

    logic [15:0] r_hw_buf [3];
    logic [1:0]  r_hw_cnt;
    logic [31:0] r_head_pc;
    logic [29:0] r_fetch_word;
    logic        r_skip_low;

    logic        w_is_c;
    logic        w_valid;
    logic        w_fire;
    logic [1:0]  w_cons;
    logic [1:0]  w_surv;
    logic [1:0]  w_n;
    logic        w_append;
    logic [1:0]  w_ncnt;
    logic [15:0] w_new_lo;
    logic [15:0] w_new_hi;
    logic [31:0] w_redir_pc;
    logic [15:0] w_nbuf [3];

`ifdef INSTR_ALIGNER_RVC_EN
    assign w_is_c = (r_hw_buf[0][1:0] != 2'b11);
`else
    assign w_is_c = 1'b0;
`endif

    assign w_valid    = ((r_hw_cnt != 2'd0) && w_is_c) || (r_hw_cnt >= 2'd2);
    assign w_fire     = w_valid && bus.instr_ready;
    assign w_cons     = !w_fire ? 2'd0 : (w_is_c ? 2'd1 : 2'd2);
    assign w_surv     = r_hw_cnt - w_cons;
    assign w_n        = r_skip_low ? 2'd1 : 2'd2;
    assign w_append   = ({1'b0, w_surv} + {1'b0, w_n}) <= 3'd3;
    assign w_ncnt     = w_surv + (w_append ? w_n : 2'd0);
    assign w_new_lo   = r_skip_low ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    assign w_new_hi   = bus.mem_rdata[31:16];
    assign w_redir_pc = bus.redirect_pc & c_PC_MASK;

    // Survivors shift down by the consumed count; fresh halfwords land right behind them.
    always_comb begin
        w_nbuf[0] = r_hw_buf[0];
        w_nbuf[1] = r_hw_buf[1];
        w_nbuf[2] = r_hw_buf[2];
        case (w_cons)
            2'd1: begin
                w_nbuf[0] = r_hw_buf[1];
                w_nbuf[1] = r_hw_buf[2];
                w_nbuf[2] = 16'h0000;
            end
            2'd2: begin
                w_nbuf[0] = r_hw_buf[2];
                w_nbuf[1] = 16'h0000;
                w_nbuf[2] = 16'h0000;
            end
            default: ;
        endcase
        if (w_append) begin
            case (w_surv)
                2'd0: begin
                    w_nbuf[0] = w_new_lo;
                    if (!r_skip_low) w_nbuf[1] = w_new_hi;
                end
                2'd1: begin
                    w_nbuf[1] = w_new_lo;
                    if (!r_skip_low) w_nbuf[2] = w_new_hi;
                end
                2'd2: w_nbuf[2] = w_new_lo;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hw_buf[0]  <= 16'h0000;
            r_hw_buf[1]  <= 16'h0000;
            r_hw_buf[2]  <= 16'h0000;
            r_hw_cnt     <= 2'd0;
            r_head_pc    <= c_RESET_PC;
            r_fetch_word <= c_RESET_PC[31:2];
            r_skip_low   <= c_RESET_PC[1];
        end else if (bus.redirect_valid) begin
            r_hw_cnt     <= 2'd0;
            r_head_pc    <= w_redir_pc;
            r_fetch_word <= w_redir_pc[31:2];
            r_skip_low   <= w_redir_pc[1];
        end else begin
            r_hw_buf[0] <= w_nbuf[0];
            r_hw_buf[1] <= w_nbuf[1];
            r_hw_buf[2] <= w_nbuf[2];
            r_hw_cnt    <= w_ncnt;
            if (w_fire) begin
                r_head_pc <= r_head_pc + (w_is_c ? 32'd2 : 32'd4);
            end
            if (w_append) begin
                r_fetch_word <= r_fetch_word + 30'd1;
                r_skip_low   <= 1'b0;
            end
        end
    end

    assign bus.mem_addr    = {r_fetch_word, 2'b00};
    assign bus.instr_valid = w_valid;
    assign bus.instr_pc    = r_head_pc;
    assign bus.instr_is_c  = w_is_c && (r_hw_cnt != 2'd0);
    assign bus.instr_data  = (r_hw_cnt == 2'd0) ? 32'h0000_0000 :
                             (w_is_c ? {16'h0000, r_hw_buf[0]} : {r_hw_buf[1], r_hw_buf[0]});

endmodule
`default_nettype wire

// File: tb/tb_instruction_aligner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_instruction_aligner                                        |
// | Brief    : Directed self-checking bench for instruction_aligner.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_instruction_aligner;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    logic [31:0] mem [64];

    instruction_aligner_if bus ();

    instruction_aligner #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
        $fatal(1);
    end

    task automatic do_reset();
        reset_n            = 1'b0;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.instr_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n            = 1'b0;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (2) @(negedge clk);
        checks += 5;
        if (bus.instr_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%0b exp=0", bus.instr_valid);
        end
        if (bus.instr_pc !== 32'h0) begin
            failures++; $display("FAIL reset_pc got=%h exp=00000000", bus.instr_pc);
        end
        if (bus.instr_data !== 32'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=00000000", bus.instr_data);
        end
        if (bus.instr_is_c !== 1'b0) begin
            failures++; $display("FAIL reset_is_c got=%0b exp=0", bus.instr_is_c);
        end
        if (bus.mem_addr !== 32'h0) begin
            failures++; $display("FAIL reset_mem_addr got=%h exp=00000000", bus.mem_addr);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr_data, bus.instr_is_c} !==
            {1'b1, 32'h0, 32'h0020_0093, 1'b0}) begin
            failures++;
            $display("FAIL first_instr got v=%0b pc=%h d=%h c=%0b exp v=1 pc=00000000 d=00200093 c=0",
                     bus.instr_valid, bus.instr_pc, bus.instr_data, bus.instr_is_c);
        end
    endtask

    task automatic test_straddle();
        logic [31:0] exp_pc   [5];
        logic [31:0] exp_data [5];
        logic        exp_c    [5];
        bit ok;
`ifdef INSTR_ALIGNER_RVC_EN
        exp_pc   = '{32'h0, 32'h4, 32'h6, 32'hA, 32'hC};
        exp_data = '{32'h0020_0093, 32'h0000_4529, 32'h0050_0593, 32'h0000_061D, 32'h0000_0013};
        exp_c    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_pc   = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        exp_data = '{32'h0020_0093, 32'h0593_4529, 32'h061D_0050, 32'h0000_0013, 32'h0000_0013};
        exp_c    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            wait_valid(ok);
            checks++;
            if (!ok || bus.instr_pc !== exp_pc[i] || bus.instr_data !== exp_data[i] ||
                bus.instr_is_c !== exp_c[i]) begin
                failures++;
                $display("FAIL straddle[%0d] got v=%0b pc=%h d=%h c=%0b exp pc=%h d=%h c=%0b",
                         i, bus.instr_valid, bus.instr_pc, bus.instr_data, bus.instr_is_c,
                         exp_pc[i], exp_data[i], exp_c[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] stall_pc;
        logic [31:0] stall_data;
        logic [31:0] exp_pc   [3];
        logic [31:0] exp_data [3];
`ifdef INSTR_ALIGNER_RVC_EN
        stall_pc   = 32'h6;
        stall_data = 32'h0050_0593;
        exp_pc     = '{32'hA, 32'hC, 32'h10};
        exp_data   = '{32'h0000_061D, 32'h0000_0013, 32'h0000_0013};
`else
        stall_pc   = 32'h8;
        stall_data = 32'h061D_0050;
        exp_pc     = '{32'hC, 32'h10, 32'h14};
        exp_data   = '{32'h0000_0013, 32'h0000_0013, 32'h0000_0013};
`endif
        do_reset();
        repeat (3) @(negedge clk);
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks += 3;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== stall_pc) begin
                failures++;
                $display("FAIL stall_pc[%0d] got v=%0b pc=%h exp v=1 pc=%h",
                         i, bus.instr_valid, bus.instr_pc, stall_pc);
            end
            if (bus.instr_data !== stall_data) begin
                failures++;
                $display("FAIL stall_data[%0d] got=%h exp=%h", i, bus.instr_data, stall_data);
            end
            if (bus.mem_addr !== 32'hC) begin
                failures++;
                $display("FAIL stall_mem_addr[%0d] got=%h exp=0000000c", i, bus.mem_addr);
            end
        end
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp_pc[i] ||
                bus.instr_data !== exp_data[i]) begin
                failures++;
                $display("FAIL resume[%0d] got v=%0b pc=%h d=%h exp v=1 pc=%h d=%h",
                         i, bus.instr_valid, bus.instr_pc, bus.instr_data, exp_pc[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] exp_pc   [2];
        logic [31:0] exp_data [2];
        bit ok;
`ifdef INSTR_ALIGNER_RVC_EN
        exp_pc   = '{32'h46, 32'h4A};
        exp_data = '{32'h00F7_2023, 32'h0013_97B3};
`else
        exp_pc   = '{32'h44, 32'h48};
        exp_data = '{32'h2023_0016, 32'h97B3_00F7};
`endif
        do_reset();
        repeat (2) @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0046;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            failures++; $display("FAIL redirect_flush got v=%0b exp v=0", bus.instr_valid);
        end
        for (int i = 0; i < 2; i++) begin
            wait_valid(ok);
            checks++;
            if (!ok || bus.instr_pc !== exp_pc[i] || bus.instr_data !== exp_data[i] ||
                bus.instr_is_c !== 1'b0) begin
                failures++;
                $display("FAIL redirect[%0d] got v=%0b pc=%h d=%h c=%0b exp pc=%h d=%h c=0",
                         i, bus.instr_valid, bus.instr_pc, bus.instr_data, bus.instr_is_c,
                         exp_pc[i], exp_data[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (4) @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks += 3;
        if (bus.instr_valid !== 1'b0 || bus.instr_is_c !== 1'b0) begin
            failures++;
            $display("FAIL async_valid got v=%0b c=%0b exp v=0 c=0", bus.instr_valid, bus.instr_is_c);
        end
        if (bus.instr_pc !== 32'h0 || bus.instr_data !== 32'h0) begin
            failures++;
            $display("FAIL async_pc_data got pc=%h d=%h exp pc=00000000 d=00000000",
                     bus.instr_pc, bus.instr_data);
        end
        if (bus.mem_addr !== 32'h0) begin
            failures++; $display("FAIL async_mem_addr got=%h exp=00000000", bus.mem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr_data} !== {1'b1, 32'h0, 32'h0020_0093}) begin
            failures++;
            $display("FAIL async_restart got v=%0b pc=%h d=%h exp v=1 pc=00000000 d=00200093",
                     bus.instr_valid, bus.instr_pc, bus.instr_data);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
        mem[0]  = 32'h0020_0093;
        mem[1]  = 32'h0593_4529;
        mem[2]  = 32'h061D_0050;
        mem[17] = 32'h2023_0016;
        mem[18] = 32'h97B3_00F7;

        test_reset();
        test_straddle();
        test_backpressure();
        test_redirect();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
